sha_msg_sched: RTL

- SHA-256 message-schedule and round-constant source for one miner core. It feeds kt, wt and r_cntr to the per-core Kt+Wt adder, acting as the producer/writer side of that interface.
- Holds one 512-bit block written word-by-word, then streams W[t]/K[t] for t=0..63 under downstream backpressure.
- One instance sits in each core/hash stage, between the block loader and the round pipeline.

---
 rtl/sha256_pkg.sv | 23 ++
 rtl/sha_w_expand.sv | 12 +
 rtl/sha_msg_sched.sv | 100 ++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 round constants, schedule sigma functions and FSM state type
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [31:0] k_tab [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] pad2 [8] = '{
    32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000100
  };
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
endpackage

// File: rtl/sha_w_expand.sv
// sha_w_expand: combinational next schedule word from the four window taps
module sha_w_expand
  import sha256_pkg::*;
(
  input  logic [31:0] w14,
  input  logic [31:0] w9,
  input  logic [31:0] w1,
  input  logic [31:0] w0,
  output logic [31:0] w_new
);
  assign w_new = sig1(w14) + w9 + sig0(w1) + w0;
endmodule

// File: rtl/sha_msg_sched.sv
// sha_msg_sched: block store plus 64-round W[t]/K[t] stream with ready handshake
module sha_msg_sched
  import sha256_pkg::*;
#(
  parameter logic [3:0] core = 4'b0,
  parameter logic [1:0] sha  = 2'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        blk_wr_en,
  input  logic [3:0]  blk_wr_idx,
  input  logic [31:0] blk_wr_data,
  input  logic        start,
  input  logic        round_rdy,
  output logic        busy,
  output logic        rnd_vld,
  output logic [5:0]  r_cntr,
  output logic [31:0] kt,
  output logic [31:0] wt,
  output logic        done
);
  state_t      state_q, state_d;
  logic [31:0] blk_q [16];
  logic [31:0] blk_d [16];
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  r_q, r_d;
  logic [31:0] kt_q, kt_d, wt_q, wt_d, w_new;
  logic        vld_q, vld_d, done_q, done_d;
  logic        unused_core;
  assign unused_core = ^core;
  sha_w_expand u_exp (.w14(win_q[14]), .w9(win_q[9]), .w1(win_q[1]), .w0(win_q[0]), .w_new(w_new));
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    win_d   = win_q;
    r_d     = r_q;
    kt_d    = kt_q;
    wt_d    = wt_q;
    vld_d   = vld_q;
    done_d  = done_q;
    if (en) begin
      done_d = 1'b0;
      if (state_q == IDLE) begin
        if (blk_wr_en && !(sha == 2'b10 && blk_wr_idx[3])) blk_d[blk_wr_idx] = blk_wr_data;
        if (start) begin
          win_d = blk_d;
          if (sha == 2'b10) for (int i = 0; i < 8; i++) win_d[8+i] = pad2[i];
          state_d = RUN;
          r_d     = 6'd0;
          wt_d    = win_d[0];
          kt_d    = k_tab[0];
          vld_d   = 1'b1;
        end
      end else if (state_q == RUN) begin
        if (round_rdy && r_q == 6'd63) begin
          state_d = DONE;
          vld_d   = 1'b0;
          done_d  = 1'b1;
        end else if (round_rdy) begin
          for (int i = 0; i < 15; i++) win_d[i] = win_q[i+1];
          win_d[15] = w_new;
          r_d  = r_q + 6'd1;
          wt_d = win_q[1];
          kt_d = k_tab[r_d];
        end
      end else begin
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '{default: '0};
      win_q   <= '{default: '0};
      r_q     <= '0;
      kt_q    <= '0;
      wt_q    <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      win_q   <= win_d;
      r_q     <= r_d;
      kt_q    <= kt_d;
      wt_q    <= wt_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end
  assign busy    = state_q != IDLE;
  assign rnd_vld = vld_q;
  assign r_cntr  = r_q;
  assign kt      = kt_q;
  assign wt      = wt_q;
  assign done    = done_q;
endmodule
